mdu_unit: RTL

- Multiply/divide unit in the EX stage of the 5-stage pipelined MIPS core.
- Executes mult/multu/div/divu over multiple cycles and owns the HI and LO registers.
- Also services mthi/mtlo writes.
- Exposes busy so the hazard unit stalls mfhi/mflo and further MDU ops in D while an operation is in flight (the stall condition is start | busy).

---
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : Request/result bundle between the EX stage and the
//                multiply/divide unit (operation request in, HI/LO and
//                busy out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues requests, observes busy and HI/LO
    modport master (
        output start, op, rs_data, rt_data,
        input  busy, hi, lo
    );

    // MDU side: consumes requests, owns busy and HI/LO
    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_unit
//  Description : Multi-cycle multiply/divide unit for the EX stage. Owns the
//                architectural HI/LO registers, executes mult/multu/div/divu
//                with fixed latencies and services mthi/mtlo immediately.
//                Optional feature macro MDU_MADD_EN adds madd/msub
//                accumulation into {HI,LO}; when undefined, ops 6/7 are
//                no-ops and no accumulator logic exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    mdu_if.slave      bus
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MSUB  = 3'd7;
`endif

    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES);

    // Architectural and in-flight state
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [63:0] r_res;
    logic        r_res_wr;

    // Products of the live operands (only meaningful in the accept cycle)
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;

    // Division datapath: magnitudes for signed divide, raw values for unsigned
    logic        w_div_signed;
    logic        w_div_zero;
    logic [31:0] w_dend;
    logic [31:0] w_dsor;
    logic [31:0] w_den;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Result selection for the accepted long-latency operation
    logic        w_long;
    logic [3:0]  w_load;
    logic [63:0] w_res;
    logic        w_res_wr;

    assign w_prod_s = $signed({{32{bus.rs_data[31]}}, bus.rs_data})
                    * $signed({{32{bus.rt_data[31]}}, bus.rt_data});
    assign w_prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};

    assign w_div_signed = (bus.op == c_OP_DIV);
    assign w_div_zero   = (bus.rt_data == 32'd0);
    assign w_dend = (w_div_signed && bus.rs_data[31]) ? (32'd0 - bus.rs_data) : bus.rs_data;
    assign w_dsor = (w_div_signed && bus.rt_data[31]) ? (32'd0 - bus.rt_data) : bus.rt_data;
    // A zero divisor never commits; dividing by one keeps the datapath X-free
    assign w_den  = w_div_zero ? 32'd1 : w_dsor;
    assign w_q_u  = w_dend / w_den;
    assign w_r_u  = w_dend % w_den;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // The magnitude form also yields 0x80000000 / -1 = 0x80000000, rem 0.
    assign w_quot = (w_div_signed && (bus.rs_data[31] ^ bus.rt_data[31])) ? (32'd0 - w_q_u) : w_q_u;
    assign w_rem  = (w_div_signed && bus.rs_data[31]) ? (32'd0 - w_r_u) : w_r_u;

`ifdef MDU_MADD_EN
    // Accumulator operand is the HI/LO value at accept time
    logic [63:0] w_acc_add;
    logic [63:0] w_acc_sub;
    assign w_acc_add = {r_hi, r_lo} + 64'(w_prod_s);
    assign w_acc_sub = {r_hi, r_lo} - 64'(w_prod_s);
`endif

    // Decode the op into latency, result value and commit enable
    always_comb begin
        w_long   = 1'b0;
        w_load   = 4'd0;
        w_res    = 64'(w_prod_s);
        w_res_wr = 1'b1;
        case (bus.op)
            c_OP_MULT: begin
                w_long = 1'b1;
                w_load = c_MULT_LOAD;
                w_res  = 64'(w_prod_s);
            end
            c_OP_MULTU: begin
                w_long = 1'b1;
                w_load = c_MULT_LOAD;
                w_res  = w_prod_u;
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_long   = 1'b1;
                w_load   = c_DIV_LOAD;
                w_res    = {w_rem, w_quot};
                w_res_wr = ~w_div_zero;
            end
`ifdef MDU_MADD_EN
            c_OP_MADD: begin
                w_long = 1'b1;
                w_load = c_MULT_LOAD;
                w_res  = w_acc_add;
            end
            c_OP_MSUB: begin
                w_long = 1'b1;
                w_load = c_MULT_LOAD;
                w_res  = w_acc_sub;
            end
`endif
            default: begin
                w_long = 1'b0;
            end
        endcase
    end

    // Accept requests when idle, count down the busy window, commit at 1->0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_res    <= 64'd0;
            r_res_wr <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
                if (r_res_wr) begin
                    r_hi <= r_res[63:32];
                    r_lo <= r_res[31:0];
                end
            end
        end else if (bus.start) begin
            if (bus.op == c_OP_MTHI) begin
                r_hi <= bus.rs_data;
            end else if (bus.op == c_OP_MTLO) begin
                r_lo <= bus.rs_data;
            end else if (w_long) begin
                r_cnt    <= w_load;
                r_busy   <= 1'b1;
                r_res    <= w_res;
                r_res_wr <= w_res_wr;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire
